ls_quad_access: RTL and testbench
=================================

# ls_quad_access

Local-store quadword access unit between the `cellspu` core and the byte-wide `exmemory` local store. Converts one 128-bit SPU load or store request into 16 sequential byte accesses on the memory port, in big-endian order. Returns the assembled quadword, or commits the store, with a busy/done handshake.

## Interface
- `WIDTH`, 32, address width and memory data-port width; matches `exmemory`.
- `LS_BITS`, 18, local-store address bits (256 KB); upper address bits are masked off.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `req`  input  1  core request strobe; sampled only in IDLE or DONE.
- `we`  input  1  1 = quadword store, 0 = quadword load; sampled with `req`.
- `addr`  input  WIDTH  byte address from the core.
- `wdata`  input  128  store data; `wdata[127:120]` is the byte at the lowest address.
- `busy`  output  1  a transfer is in progress.
- `done`  output  1  one-cycle completion pulse.
- `rdata`  output  128  last loaded quadword; `rdata[127:120]` is the byte at the lowest address.
- `memdata`  input  WIDTH  byte read from the store; bits [7:0] are used, upper bits are ignored.
- `memread`  output  1  high during load byte cycles.
- `memwrite`  output  1  high during store byte cycles.
- `mem_adr`  output  WIDTH  byte address to the store.
- `mem_writedata`  output  WIDTH  {(WIDTH-8)'b0, store byte}.

## Operation
- Effective base address: `base = addr & ((1<<LS_BITS)-1) & ~15`. Low 4 address bits and bits at or above `LS_BITS` are ignored, so accesses wrap inside the local store and never cross a quadword.
- States:
  - IDLE.
  - XFER: 4-bit counter `cnt` runs 0 to 15.
  - DONE.
- IDLE or DONE with `req=1`:
  - Latch `base`, `we`, and `wdata`.
  - Set `cnt=0` and go to XFER.
- IDLE or DONE with `req=0`: go to IDLE.
- XFER, every cycle:
  - `mem_adr = base + cnt`.
  - Load: `memread=1`. At the clock edge, capture `memdata[7:0]` into byte lane `cnt` of the assembly register (lane 0 = bits [127:120]).
  - Store: `memwrite=1`, `mem_writedata[7:0] = wdata` lane `cnt`.
  - `cnt` increments each cycle. When `cnt=15`, go to DONE.
- DONE: `done=1` for one cycle.
  - Load: `rdata` is updated from the assembly register on entry to DONE and held until the next load completes.
  - Store: `rdata` is unchanged.
- `req` in XFER is ignored, not queued. The core must hold off while `busy=1`.
- Outside XFER: `memread=0`, `memwrite=0`, `mem_adr=0`, `mem_writedata=0`.
- Reset mid-transfer:
  - The transfer is aborted and the state returns to IDLE.
  - Store bytes already written stay in memory; no further writes occur.
  - `rdata` returns to 0.

## Timing
- Reset values: `busy=0`, `done=0`, `rdata=0`, `memread=0`, `memwrite=0`, `mem_adr=0`, `mem_writedata=0`, state IDLE.
- Request accepted at edge E0. Byte cycles follow E0 through E15. `busy=1` for exactly those 16 cycles.
- `done=1` in the 17th cycle after E0. Loaded `rdata` is valid in the same cycle as `done`.
- The `exmemory` read path is combinational: `memdata` is valid in the same cycle as `mem_adr`.
- Back-to-back: `req` held high in DONE is accepted at the DONE edge. Sustained rate is one quadword per 17 cycles.
- `busy`, `done`, `memread`, `memwrite`, `mem_adr`, and `mem_writedata` are decoded from registered state only. No combinational path from `req`/`addr` to the memory port.

## Test plan
- **Load**
  - Stimulus: memory bytes 0x00..0x0F hold 0x10..0x1F; `req=1`, `we=0`, `addr=0x0000_0007`.
  - Required response: `mem_adr` steps 0x0 to 0xF; `busy` high for 16 cycles; `done` pulses 17 cycles after accept; `rdata=0x101112131415161718191A1B1C1D1E1F`.
- **Store then load**
  - Stimulus: store `wdata=0xDEADBEEF_00112233_44556677_8899AABB` at `addr=0x40`, then load from 0x40.
  - Required response: byte 0x40 = 0xDE, byte 0x4F = 0xBB; the load returns the same 128-bit value; `memwrite` is high for exactly 16 cycles.
- **Address masking**
  - Stimulus: load with `addr=0xFFFF_FFF3`.
  - Required response: `mem_adr` runs 0x3FFF0..0x3FFFF; no address above `(1<<LS_BITS)-1` appears.
- **Back-to-back and ignored requests**
  - Stimulus: hold `req=1` across two loads; pulse `req` mid-XFER.
  - Required response: the second load is accepted at the DONE edge; there are exactly two `done` pulses; the mid-XFER pulse produces no extra transfer.
- **Reset mid-store**
  - Stimulus: assert `reset` asynchronously after 5 store byte cycles.
  - Required response: all outputs are 0 immediately; exactly bytes base+0..base+4 are modified; the next request completes normally.

Source files
------------

// File: rtl/ls_quad_access_if.sv
// Core/local-store bundle for the quadword access unit: SPU request side plus
// the byte-wide memory port. The unit attaches through the slave modport.
interface ls_quad_access_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-1:0] addr;
  logic [127:0]     wdata;
  logic             busy;
  logic             done;
  logic [127:0]     rdata;
  logic [WIDTH-1:0] memdata;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_writedata;

  modport slave (
    input  req, we, addr, wdata, memdata,
    output busy, done, rdata, memread, memwrite, mem_adr, mem_writedata
  );

  modport master (
    output req, we, addr, wdata, memdata,
    input  busy, done, rdata, memread, memwrite, mem_adr, mem_writedata
  );
endinterface

// File: rtl/ls_quad_access.sv
// Quadword load/store sequencer: one 128-bit request becomes 16 big-endian
// byte accesses on the local-store port, with a busy/done handshake.
module ls_quad_access #(
  parameter int WIDTH   = 32,
  parameter int LS_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  ls_quad_access_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] LS_MASK = WIDTH'((64'd1 << LS_BITS) - 64'd1);
  localparam logic [WIDTH-1:0] QW_MASK = {{(WIDTH-4){1'b1}}, 4'b0000};

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg;
  logic [WIDTH-1:0] base_reg;
  logic             we_reg;
  logic [127:0]     wdata_reg;
  logic [127:0]     rdata_reg;
  logic [119:0]     asm_bits;
  logic [7:0]       wlane [0:15];
  logic             xfer;
  logic             accept;
  logic             last;
  logic             unused_bits;

  assign xfer   = (state_reg == XFER);
  assign accept = (state_reg != XFER) && bus.req;
  assign last   = xfer && (cnt_reg == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = bus.req ? XFER : IDLE;
      XFER:       if (cnt_reg == 4'd15) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= 4'd0;
      base_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else if (accept) begin
      base_reg  <= bus.addr & LS_MASK & QW_MASK;
      we_reg    <= bus.we;
      wdata_reg <= bus.wdata;
      cnt_reg   <= 4'd0;
    end else if (xfer) begin
      cnt_reg <= cnt_reg + 4'd1;
      // Final byte goes straight from the port into rdata with lanes 0..14.
      if (last && !we_reg) rdata_reg <= {asm_bits, bus.memdata[7:0]};
    end
  end

  // Assembly lanes 0..14; lane 0 is the lowest address, i.e. the MSB byte.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          lane_reg <= 8'd0;
        else if (xfer && !we_reg && cnt_reg == 4'(gi))
          lane_reg <= bus.memdata[7:0];
      end
      assign asm_bits[119-8*gi -: 8] = lane_reg;
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_wlane
      assign wlane[gi] = wdata_reg[127-8*gi -: 8];
    end
  endgenerate

  assign bus.busy          = xfer;
  assign bus.done          = (state_reg == DONE);
  assign bus.rdata         = rdata_reg;
  assign bus.memread       = xfer && !we_reg;
  assign bus.memwrite      = xfer && we_reg;
  // Base is quadword aligned, so OR-ing the counter in is the same as adding.
  assign bus.mem_adr       = xfer ? (base_reg | {{(WIDTH-4){1'b0}}, cnt_reg}) : '0;
  assign bus.mem_writedata = (xfer && we_reg) ? {{(WIDTH-8){1'b0}}, wlane[cnt_reg]} : '0;

  assign unused_bits = &{1'b0, bus.memdata[WIDTH-1:8]};
endmodule

// File: tb/tb_ls_quad_access.sv
// Directed bench for ls_quad_access with a byte-wide local-store model.
module tb_ls_quad_access;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   failed = 0;

  logic [7:0] mem [0:(1<<18)-1];
  int   memwrite_cycles = 0;
  int   done_pulses = 0;
  bit   adr_over = 1'b0;

  ls_quad_access_if #(.WIDTH(WIDTH)) bus ();

  ls_quad_access #(.WIDTH(WIDTH), .LS_BITS(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.memdata = {24'h0, mem[bus.mem_adr[17:0]]};

  // Memory model and event counters share one process with the init.
  initial begin
    for (int i = 0; i < (1 << 18); i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      mem[i]           = 8'h10 + 8'(i);
      mem[32'h3FFF0+i] = 8'hA0 + 8'(i);
    end
    forever begin
      @(posedge clk);
      if (bus.memwrite) begin
        mem[bus.mem_adr[17:0]] = bus.mem_writedata[7:0];
        memwrite_cycles++;
      end
      if (bus.done) done_pulses++;
      if ((bus.memread || bus.memwrite) && bus.mem_adr > 32'h3FFFF) adr_over = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and check every byte cycle plus the done cycle.
  task automatic run_xfer(input string tag, input logic w, input logic [31:0] a,
                          input logic [127:0] d, input logic [31:0] exp_base);
    logic [127:0] sh;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check({tag, " busy"}, 128'(bus.busy), 128'(1));
      check({tag, " mem_adr"}, 128'(bus.mem_adr), 128'(exp_base + 32'(i)));
      check({tag, " memread"}, 128'(bus.memread), 128'(!w));
      check({tag, " memwrite"}, 128'(bus.memwrite), 128'(w));
      sh = d >> (8 * (15 - i));
      check({tag, " mem_writedata"}, 128'(bus.mem_writedata), w ? 128'(sh[7:0]) : 128'(0));
      tick();
    end
    check({tag, " done"}, 128'(bus.done), 128'(1));
    check({tag, " busy_off"}, 128'(bus.busy), 128'(0));
    $display("[TB] %s we=%0d addr=%h rdata=%h", tag, w, a, bus.rdata);
  endtask

  localparam logic [127:0] LOAD0  = 128'h101112131415161718191A1B1C1D1E1F;
  localparam logic [127:0] STV    = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [127:0] HIGHQ  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
  localparam logic [127:0] W2     = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] PART   = 128'h01234567890000000000000000000000;

  initial begin
    int wc0, dp0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // Reset state
    tick(); tick();
    check("rst busy", 128'(bus.busy), 128'(0));
    check("rst done", 128'(bus.done), 128'(0));
    check("rst rdata", bus.rdata, 128'(0));
    check("rst memread", 128'(bus.memread), 128'(0));
    check("rst memwrite", 128'(bus.memwrite), 128'(0));
    check("rst mem_adr", 128'(bus.mem_adr), 128'(0));
    check("rst mem_writedata", 128'(bus.mem_writedata), 128'(0));
    reset = 1'b0;
    tick();

    // Load from a misaligned address
    run_xfer("load0", 1'b0, 32'h0000_0007, '0, 32'h0);
    check("load0 rdata", bus.rdata, LOAD0);
    tick();
    check("load0 done_once", 128'(bus.done), 128'(0));
    check("idle mem_adr", 128'(bus.mem_adr), 128'(0));

    // Store then load back
    wc0 = memwrite_cycles;
    run_xfer("store40", 1'b1, 32'h40, STV, 32'h40);
    check("store rdata_kept", bus.rdata, LOAD0);
    tick();
    check("store byte40", 128'(mem[32'h40]), 128'(8'hDE));
    check("store byte4F", 128'(mem[32'h4F]), 128'(8'hBB));
    check("store memwrite_cycles", 128'(memwrite_cycles - wc0), 128'(16));
    run_xfer("load40", 1'b0, 32'h40, '0, 32'h40);
    check("load40 rdata", bus.rdata, STV);
    tick();

    // Address masking at the top of the local store
    run_xfer("loadmask", 1'b0, 32'hFFFF_FFF3, '0, 32'h3FFF0);
    check("loadmask rdata", bus.rdata, HIGHQ);
    check("loadmask range", 128'(adr_over), 128'(0));
    tick();

    // Back-to-back with req held, plus an ignored mid-XFER pulse
    dp0 = done_pulses;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0;
    tick();
    for (int i = 0; i < 16; i++) tick();
    check("b2b first done", 128'(bus.done), 128'(1));
    check("b2b first rdata", bus.rdata, LOAD0);
    $display("[TB] b2b first rdata=%h", bus.rdata);
    bus.addr = 32'h40;
    tick();
    check("b2b accept busy", 128'(bus.busy), 128'(1));
    check("b2b accept done", 128'(bus.done), 128'(0));
    bus.req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("b2b mem_adr", 128'(bus.mem_adr), 128'(32'h40 + 32'(i)));
      if (i == 5) bus.req = 1'b1;
      if (i == 6) bus.req = 1'b0;
      tick();
    end
    check("b2b second done", 128'(bus.done), 128'(1));
    check("b2b second rdata", bus.rdata, STV);
    $display("[TB] b2b second rdata=%h", bus.rdata);
    tick();
    check("b2b no_extra busy1", 128'(bus.busy), 128'(0));
    tick();
    check("b2b no_extra busy2", 128'(bus.busy), 128'(0));
    check("b2b done_pulses", 128'(done_pulses - dp0), 128'(2));

    // Reset after five store byte cycles
    wc0 = memwrite_cycles;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h80; bus.wdata = W2;
    tick();
    bus.req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("midrst memwrite_pre", 128'(bus.memwrite), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("midrst busy", 128'(bus.busy), 128'(0));
    check("midrst memwrite", 128'(bus.memwrite), 128'(0));
    check("midrst mem_adr", 128'(bus.mem_adr), 128'(0));
    check("midrst mem_writedata", 128'(bus.mem_writedata), 128'(0));
    check("midrst rdata", bus.rdata, 128'(0));
    tick(); tick();
    reset = 1'b0;
    tick();
    check("midrst writes", 128'(memwrite_cycles - wc0), 128'(5));
    check("midrst byte84", 128'(mem[32'h84]), 128'(8'h89));
    check("midrst byte85", 128'(mem[32'h85]), 128'(8'h00));
    $display("[TB] reset mid-store at 0x80 after 5 byte cycles");
    run_xfer("load80", 1'b0, 32'h80, '0, 32'h80);
    check("load80 rdata", bus.rdata, PART);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
